// File: rtl/id_hazard_scheduler.sv
// Decode-stage issue controller: per-register pending-write scoreboard, hazard stall and one-cycle post-branch flush.
// Latency: hazard/issue/flush are combinational from inputs and registered state; counters, state and stall_count update on the next clk edge.
// Backpressure: hazard freezes IF/ID and bubbles EXE; writeback clears are not bypassed, so a released source issues one cycle after its writeback.
//
// Optional feature macro: HAZARD_FORWARD_EN (load-use-only stalling, with operands supplied by the EXE/MEM forwarding unit).
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   id_valid            decode holds a valid instruction
//   id_src_1/id_src_2   source indices (id_two_src qualifies id_src_2)
//   id_wb_en/id_dest    instruction writes id_dest (pre-hazard value)
//   id_mem_r_en         instruction is a load
//   id_b                instruction is a taken branch
//   wb_wb_en/wb_dest    writeback-stage register write port
//   hazard/issue/flush  stall, advance, discard-IF/ID controls
//   busy_mask           bit r set while register r has pending writes
//   stall_count         saturating count of hazard cycles
//   sb_err              sticky flag: decrement of an empty counter
module id_hazard_scheduler #(
  parameter int NUM_REGS    = 16,
  parameter int CNT_W       = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [3:0]             id_src_1,
  input  logic [3:0]             id_src_2,
  input  logic                   id_two_src,
  input  logic                   id_wb_en,
  input  logic [3:0]             id_dest,
  input  logic                   id_mem_r_en,
  input  logic                   id_b,
  input  logic                   wb_wb_en,
  input  logic [3:0]             wb_dest,
  output logic                   hazard,
  output logic                   issue,
  output logic                   flush,
  output logic [NUM_REGS-1:0]    busy_mask,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic                   sb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [CNT_W-1:0]         r_cnt [NUM_REGS];
  logic [STALL_CNT_W-1:0]   r_stall_count;
  logic                     r_sb_err;
  logic                     w_dep;
  logic                     w_dest_sat;
  logic                     w_hazard;
  logic                     w_issue;
  logic [NUM_REGS-1:0]      w_inc;
  logic [NUM_REGS-1:0]      w_dec;

  // A destination whose counter is full cannot accept another in-flight write.
  assign w_dest_sat = id_wb_en && (r_cnt[id_dest] == CNT_MAX);

`ifdef HAZARD_FORWARD_EN
  logic       r_ld_valid;
  logic [3:0] r_ld_dest;

  // Only the load issued in the previous cycle can be unforwardable.
  assign w_dep = (r_ld_valid && ((id_src_1 == r_ld_dest) ||
                                 (id_two_src && (id_src_2 == r_ld_dest)))) ||
                 w_dest_sat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ld_valid <= 1'b0;
      r_ld_dest  <= '0;
    end else begin
      r_ld_valid <= w_issue && id_mem_r_en && id_wb_en;
      r_ld_dest  <= id_dest;
    end
  end
`else
  logic w_unused_mem_r_en;
  assign w_unused_mem_r_en = id_mem_r_en;

  assign w_dep = (r_cnt[id_src_1] != '0) ||
                 (id_two_src && (r_cnt[id_src_2] != '0)) ||
                 w_dest_sat;
`endif

  // The wrong-path instruction sitting in decode during FLUSH is ignored.
  assign w_hazard = id_valid && w_dep && (r_state != ST_FLUSH);
  assign w_issue  = id_valid && !w_dep && (r_state != ST_FLUSH);

  assign hazard      = w_hazard;
  assign issue       = w_issue;
  assign flush       = (r_state == ST_FLUSH);
  assign stall_count = r_stall_count;
  assign sb_err      = r_sb_err;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_hazard)          w_state_nxt = ST_STALL;
        else if (w_issue && id_b) w_state_nxt = ST_FLUSH;
      end
      ST_STALL: begin
        if (w_issue && id_b)   w_state_nxt = ST_FLUSH;
        else if (w_issue)      w_state_nxt = ST_RUN;
        else if (!id_valid)    w_state_nxt = ST_RUN;
      end
      ST_FLUSH:                w_state_nxt = ST_RUN;
      default:                 w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_RUN;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_inc     = '0;
    w_dec     = '0;
    busy_mask = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_inc[r]     = w_issue && id_wb_en && (id_dest == 4'(r));
      w_dec[r]     = wb_wb_en && (wb_dest == 4'(r));
      busy_mask[r] = (r_cnt[r] != '0);
    end
  end

  // A simultaneous issue-write and writeback to one register cancel out.
  // Increment cannot overflow: a saturated destination blocks issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) r_cnt[r] <= '0;
      r_sb_err <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (w_inc[r] && !w_dec[r]) begin
          r_cnt[r] <= r_cnt[r] + 1'b1;
        end else if (w_dec[r] && !w_inc[r]) begin
          if (r_cnt[r] == '0) r_sb_err <= 1'b1;
          else                r_cnt[r] <= r_cnt[r] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  r_stall_count <= '0;
    else if (w_hazard && (r_stall_count != '1)) r_stall_count <= r_stall_count + 1'b1;
  end

endmodule

// File: tb/tb_id_hazard_scheduler.sv
module tb_id_hazard_scheduler;

  typedef struct {
    logic        v;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic        two;
    logic        wb;
    logic [3:0]  d;
    logic        mr;
    logic        b;
    logic        wbwb;
    logic [3:0]  wbd;
    logic        hz;
    logic        is;
    logic        fl;
    logic [15:0] busy;
    logic [15:0] stall;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        id_valid = 1'b0;
  logic [3:0]  id_src_1 = '0;
  logic [3:0]  id_src_2 = '0;
  logic        id_two_src = 1'b0;
  logic        id_wb_en = 1'b0;
  logic [3:0]  id_dest = '0;
  logic        id_mem_r_en = 1'b0;
  logic        id_b = 1'b0;
  logic        wb_wb_en = 1'b0;
  logic [3:0]  wb_dest = '0;
  logic        hazard;
  logic        issue;
  logic        flush;
  logic [15:0] busy_mask;
  logic [15:0] stall_count;
  logic        sb_err;

  int checks = 0;
  int failures = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  id_hazard_scheduler #(.NUM_REGS(16), .CNT_W(2), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_src_1(id_src_1), .id_src_2(id_src_2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_dest(id_dest),
    .id_mem_r_en(id_mem_r_en), .id_b(id_b),
    .wb_wb_en(wb_wb_en), .wb_dest(wb_dest),
    .hazard(hazard), .issue(issue), .flush(flush),
    .busy_mask(busy_mask), .stall_count(stall_count), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                              input logic two, input logic wb, input logic [3:0] d,
                              input logic mr, input logic b, input logic wbwb,
                              input logic [3:0] wbd, input logic hz, input logic is,
                              input logic fl, input logic [15:0] busy,
                              input logic [15:0] stall, input logic err);
    vec_t x;
    x.v = v; x.s1 = s1; x.s2 = s2; x.two = two; x.wb = wb; x.d = d; x.mr = mr; x.b = b;
    x.wbwb = wbwb; x.wbd = wbd; x.hz = hz; x.is = is; x.fl = fl; x.busy = busy;
    x.stall = stall; x.err = err;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare mid-cycle.
  task automatic step(input string tag, input vec_t x);
    vec_t e;
    @(posedge clk);
    #1;
    id_valid = x.v; id_src_1 = x.s1; id_src_2 = x.s2; id_two_src = x.two;
    id_wb_en = x.wb; id_dest = x.d; id_mem_r_en = x.mr; id_b = x.b;
    wb_wb_en = x.wbwb; wb_dest = x.wbd;
    exp_q.push_back(x);
    #3;
    e = exp_q.pop_front();
    chk({tag, " hazard"}, 32'(hazard), 32'(e.hz));
    chk({tag, " issue"}, 32'(issue), 32'(e.is));
    chk({tag, " flush"}, 32'(flush), 32'(e.fl));
    chk({tag, " busy_mask"}, 32'(busy_mask), 32'(e.busy));
    chk({tag, " stall_count"}, 32'(stall_count), 32'(e.stall));
    chk({tag, " sb_err"}, 32'(sb_err), 32'(e.err));
  endtask

  // Asynchronous reset pulse placed between clock edges, with inputs idle.
  task automatic reset_pulse(input string tag);
    @(posedge clk);
    #1;
    id_valid = 0; id_wb_en = 0; id_b = 0; wb_wb_en = 0; id_mem_r_en = 0; id_two_src = 0;
    #1 rst = 1'b0;
    #2;
    chk({tag, " busy_mask"}, 32'(busy_mask), 32'h0);
    chk({tag, " stall_count"}, 32'(stall_count), 32'h0);
    chk({tag, " sb_err"}, 32'(sb_err), 32'h0);
    chk({tag, " hazard"}, 32'(hazard), 32'h0);
    chk({tag, " issue"}, 32'(issue), 32'h0);
    chk({tag, " flush"}, 32'(flush), 32'h0);
    #2 rst = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // Leave R3 with two pending writes, then reset mid-flight.
    step("pre_r3_a", mk(1,0,0,0,1,3,0,0,0,0, 0,1,0,16'h0000,0,0));
    step("pre_r3_b", mk(1,0,0,0,1,3,0,0,0,0, 0,1,0,16'h0008,0,0));
    reset_pulse("rst_r3_pending");

`ifdef HAZARD_FORWARD_EN
    tbl.push_back(mk(1,0,0,0,1,1,1,0,0,0, 0,1,0,16'h0000,0,0)); // LDR R1
    tbl.push_back(mk(1,1,3,1,1,2,0,0,0,0, 1,0,0,16'h0002,0,0)); // ADD R2<-R1,R3 bubble
    tbl.push_back(mk(1,1,3,1,1,2,0,0,0,0, 0,1,0,16'h0002,1,0)); // issues after one bubble
    tbl.push_back(mk(1,0,0,0,1,4,0,0,0,0, 0,1,0,16'h0006,1,0)); // MOV R4
    tbl.push_back(mk(1,4,0,0,1,5,0,0,0,0, 0,1,0,16'h0016,1,0)); // dependent on R4, no stall
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,16'h0036,1,0));
`else
    // ADD R2<-R1,R0 then SUB R4<-R2,R5: three stall cycles, released after WB of R2
    tbl.push_back(mk(1,1,0,1,1,2,0,0,0,0, 0,1,0,16'h0000,0,0));
    tbl.push_back(mk(1,2,5,1,1,4,0,0,0,0, 1,0,0,16'h0004,0,0));
    tbl.push_back(mk(1,2,5,1,1,4,0,0,0,0, 1,0,0,16'h0004,1,0));
    tbl.push_back(mk(1,2,5,1,1,4,0,0,1,2, 1,0,0,16'h0004,2,0));
    tbl.push_back(mk(1,2,5,1,1,4,0,0,0,0, 0,1,0,16'h0000,3,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,4, 0,0,0,16'h0010,3,0));
    // Taken branch from RUN; wrong-path write to R6 during FLUSH is dropped
    tbl.push_back(mk(1,0,0,0,0,0,0,1,0,0, 0,1,0,16'h0000,3,0));
    tbl.push_back(mk(1,0,0,0,1,6,0,0,0,0, 0,0,1,16'h0000,3,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,16'h0000,3,0));
    // Taken branch that first stalls on R8
    tbl.push_back(mk(1,0,0,0,1,8,0,0,0,0, 0,1,0,16'h0000,3,0));
    tbl.push_back(mk(1,8,0,0,0,0,0,1,0,0, 1,0,0,16'h0100,3,0));
    tbl.push_back(mk(1,8,0,0,0,0,0,1,1,8, 1,0,0,16'h0100,4,0));
    tbl.push_back(mk(1,8,0,0,0,0,0,1,0,0, 0,1,0,16'h0000,5,0));
    tbl.push_back(mk(1,0,0,0,1,6,0,0,0,0, 0,0,1,16'h0000,5,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,16'h0000,5,0));
    // Second source only checked when id_two_src; dropping id_valid leaves STALL
    tbl.push_back(mk(1,0,0,0,1,8,0,0,0,0, 0,1,0,16'h0000,5,0));
    tbl.push_back(mk(1,0,8,0,0,0,0,0,0,0, 0,1,0,16'h0100,5,0));
    tbl.push_back(mk(1,0,8,1,0,0,0,0,1,8, 1,0,0,16'h0100,5,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,16'h0000,6,0));
    // Same-cycle increment and decrement of R7
    tbl.push_back(mk(1,0,0,0,1,7,0,0,0,0, 0,1,0,16'h0000,6,0));
    tbl.push_back(mk(1,0,0,0,1,7,0,0,1,7, 0,1,0,16'h0080,6,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,7, 0,0,0,16'h0080,6,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,16'h0000,6,0));
    // Saturate R5 (max 3) so a fourth writer stalls
    tbl.push_back(mk(1,0,0,0,1,5,0,0,0,0, 0,1,0,16'h0000,6,0));
    tbl.push_back(mk(1,0,0,0,1,5,0,0,0,0, 0,1,0,16'h0020,6,0));
    tbl.push_back(mk(1,0,0,0,1,5,0,0,0,0, 0,1,0,16'h0020,6,0));
    tbl.push_back(mk(1,0,0,0,1,5,0,0,0,0, 1,0,0,16'h0020,6,0));
    tbl.push_back(mk(1,0,0,0,1,5,0,0,1,5, 1,0,0,16'h0020,7,0));
    tbl.push_back(mk(1,0,0,0,1,5,0,0,0,0, 0,1,0,16'h0020,8,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,5, 0,0,0,16'h0020,8,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,5, 0,0,0,16'h0020,8,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,5, 0,0,0,16'h0020,8,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,16'h0000,8,0));
    // Writeback to empty R9 sets the sticky error
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,9, 0,0,0,16'h0000,8,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,16'h0000,8,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,16'h0000,8,1));
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("row%0d", i), tbl[i]);
    end

    reset_pulse("rst_final");
    step("post_rst", mk(1,0,0,0,0,0,0,0,0,0, 0,1,0,16'h0000,0,0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_hazard_scheduler.md
# id_hazard_scheduler

Scoreboard-based issue controller for the decode stage. Tracks in-flight register writes between issue and writeback, and raises `hazard` to freeze IF/ID when an operand is not ready. Sequences a one-cycle `flush` after a taken branch issues. Sits beside the decode stage, taking its operand, destination and control fields plus the writeback-stage write port, and driving the decode stage's `hazard` input.

## Interface
- `NUM_REGS`, default 16: architectural registers tracked; index width is 4.
- `CNT_W`, default 2: width of each per-register pending counter; max value is 2^CNT_W−1.
- `STALL_CNT_W`, default 16: width of the stall performance counter.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `id_valid` in 1: the decode stage holds a valid instruction.
- `id_src_1` in 4: Rn index.
- `id_src_2` in 4: second source index (Rm, or Rd for stores).
- `id_two_src` in 1: `id_src_2` is read.
- `id_wb_en` in 1: the instruction writes `id_dest`. This is the pre-hazard value: control-unit output ANDed with condition pass, never gated by `hazard`.
- `id_dest` in 4: destination index.
- `id_mem_r_en` in 1: the instruction is a load.
- `id_b` in 1: the instruction is a taken branch (condition passed).
- `wb_wb_en` in 1: writeback-stage register write this cycle.
- `wb_dest` in 4: writeback destination.
- `hazard` out 1: stall IF/ID and bubble into EXE.
- `issue` out 1: the decode instruction advances this cycle.
- `flush` out 1: discard the IF/ID contents.
- `busy_mask` out NUM_REGS: bit r is set when the pending count of register r is non-zero.
- `stall_count` out STALL_CNT_W: saturating count of hazard cycles.
- `sb_err` out 1: sticky flag, set on a decrement of a zero counter.

## Operation
- State machine with states RUN (encoding 0), STALL (1), FLUSH (2).
- Dependency `dep` is computed from registered state only:
  - `cnt[id_src_1]` ≠ 0, or
  - `id_two_src` and `cnt[id_src_2]` ≠ 0, or
  - `id_wb_en` and `cnt[id_dest]` equals its maximum value.
- `hazard` = `id_valid` & `dep` & (state ≠ FLUSH).
- `issue` = `id_valid` & ~`dep` & (state ≠ FLUSH).
- `flush` = (state == FLUSH).
- Transitions:
  - RUN: `hazard` → STALL; `issue` & `id_b` → FLUSH; otherwise stay in RUN.
  - STALL: `issue` & `id_b` → FLUSH; `issue` → RUN; `id_valid` dropped → RUN; otherwise stay in STALL.
  - FLUSH: → RUN unconditionally after one cycle. The instruction in decode during FLUSH is wrong-path; it is neither issued nor scoreboarded.
- Counter updates:
  - Increment `cnt[id_dest]` when `issue` & `id_wb_en`.
  - Decrement `cnt[wb_dest]` when `wb_wb_en`.
  - Increment and decrement of the same register in the same cycle leave it unchanged.
  - A decrement at zero holds the counter at zero and sets `sb_err`.
- `stall_count` increments on every cycle with `hazard`=1 and saturates at all-ones.
- Writeback clears are not bypassed. A source whose last writer is in writeback this cycle still stalls; it is released the next cycle.

## Timing
- `hazard`, `issue` and `flush` are combinational from inputs and registered state. No path runs from `hazard` back into any input.
- Counter, state and `stall_count` updates occur on the `clk` rising edge and are visible the next cycle.
- Load-use with no forwarding: a dependent instruction stalls until the producer's writeback cycle has completed.
- Reset (asynchronous, at any time including mid-stall or mid-flush) forces:
  - state RUN;
  - all counters 0, `busy_mask`=0;
  - `stall_count`=0, `sb_err`=0;
  - `hazard`=0, `issue`=0, `flush`=0 while `id_valid`=0.
- Deasserting `rst` takes effect at the next `clk` edge. There is no extra latency.

## Configuration
- `HAZARD_FORWARD_EN` defined:
  - Counter-based source stalls are disabled; the EXE/MEM forwarding unit supplies operands.
  - The block registers `ld_dest` and `ld_valid` (set when `issue` & `id_mem_r_en` & `id_wb_en`, cleared otherwise each cycle).
  - `dep` = `ld_valid` & (`id_src_1`==`ld_dest` | (`id_two_src` & `id_src_2`==`ld_dest`)), or `cnt[id_dest]` saturated.
  - This gives exactly one bubble per load-use.
  - The counters still track in-flight writes for saturation, `busy_mask` and `sb_err`.
- Undefined: full scoreboard stalling as described in Operation. `ld_*` registers are not present.

## Test plan
- Reset with R3 pending, then release → `busy_mask`=0, `stall_count`=0, state RUN, `hazard`=0.
- Issue ADD R2←R1,R0, then immediately SUB R4←R2,R5 → `hazard`=1 for 3 cycles, released the cycle after `wb_wb_en` with `wb_dest`=2; `stall_count`=3.
- Issue a taken B (`id_b`=1) → `flush`=1 exactly the next cycle, `issue`=0 during that cycle, then RUN.
- Same cycle: issue a write to R7 while `wb_wb_en` with `wb_dest`=7 and `cnt[7]`=1 → `cnt[7]` stays 1, `busy_mask[7]`=1.
- `wb_wb_en` with `wb_dest`=9 while `cnt[9]`=0 → `sb_err`=1 and stays set until reset; `cnt[9]`=0.
- With `HAZARD_FORWARD_EN`: LDR R1, followed by ADD R2←R1,R3 → exactly one `hazard` cycle. A non-load producer followed by a dependent instruction → no stall.
